// File: rtl/maxpool_pkg.sv
// Shared constants for the 2x2 stride-2 max-pool receiver: window geometry,
// argmax position encodings and the line-buffer address width helper.
package maxpool_pkg;

  localparam int unsigned POOL_SIZE   = 2;
  localparam int unsigned POOL_STRIDE = 2;

  localparam logic [1:0] IDX_TL = 2'd0;
  localparam logic [1:0] IDX_TR = 2'd1;
  localparam logic [1:0] IDX_BL = 2'd2;
  localparam logic [1:0] IDX_BR = 2'd3;

  function automatic int unsigned lb_addr_w(input int unsigned ox);
    return ((ox / POOL_STRIDE) > 1) ? $clog2(ox / POOL_STRIDE) : 1;
  endfunction

endpackage

// File: rtl/fmap_max2.sv
// One-channel unsigned max of two values; o_b_gt is set only when b is
// strictly greater, so ties always keep a.
module fmap_max2 #(
  parameter int unsigned W = 20
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_max,
  output logic         o_b_gt
);

  assign o_b_gt = (i_b > i_a);
  assign o_max  = o_b_gt ? i_b : i_a;

endmodule

// File: rtl/fmap_maxpool_rx.sv
// 2x2 stride-2 per-channel max pooling on a raster-ordered fmap stream.
// Define MAXPOOL_RX_ARGMAX_EN to add the per-channel window argmax output o_ot_idx.
module fmap_maxpool_rx
  import maxpool_pkg::*;
#(
  parameter int unsigned CO     = 3,
  parameter int unsigned I_F_BW = 20,
  parameter int unsigned OX     = 24,
  parameter int unsigned OY     = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_in_valid,
  input  logic [CO*I_F_BW-1:0] i_in_fmap,
  output logic                 o_ot_valid,
  output logic [CO*I_F_BW-1:0] o_ot_fmap,
  output logic                 o_frame_done
`ifdef MAXPOOL_RX_ARGMAX_EN
  ,
  output logic [CO*2-1:0]      o_ot_idx
`endif
);

  localparam int unsigned FW   = CO * I_F_BW;
  localparam int unsigned XW   = (OX > 1) ? $clog2(OX) : 1;
  localparam int unsigned YW   = (OY > 1) ? $clog2(OY) : 1;
  localparam int unsigned LB_N = OX / POOL_STRIDE;
  localparam int unsigned AW   = lb_addr_w(OX);
`ifdef MAXPOOL_RX_ARGMAX_EN
  localparam int unsigned LB_DW = FW + CO;
`else
  localparam int unsigned LB_DW = FW;
`endif

  generate
    if ((OX % POOL_SIZE) != 0 || (OY % POOL_SIZE) != 0) begin : g_odd_dims
      $error("fmap_maxpool_rx: OX and OY must both be even");
    end
  endgenerate

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [FW-1:0]    r_h;
  logic [LB_DW-1:0] r_lb [LB_N];
  logic             r_ot_valid;
  logic             r_frame_done;
  logic [FW-1:0]    r_ot_fmap;

  logic             w_x_odd, w_y_odd, w_x_last, w_y_last, w_win_done;
  logic [AW-1:0]    w_addr;
  logic [FW-1:0]    w_hmax, w_vmax, w_top;
  logic [CO-1:0]    w_h_gt, w_v_gt;
  logic [LB_DW-1:0] w_lb_wr, w_lb_rd;

  assign w_x_odd    = r_x[0];
  assign w_y_odd    = r_y[0];
  assign w_x_last   = (r_x == XW'(OX - 1));
  assign w_y_last   = (r_y == YW'(OY - 1));
  assign w_win_done = i_in_valid && w_x_odd && w_y_odd;
  assign w_addr     = AW'(r_x >> 1);
  assign w_lb_rd    = r_lb[w_addr];
  assign w_top      = w_lb_rd[FW-1:0];

  // Horizontal stage compares left (h_reg) vs right (incoming); vertical compares top vs bottom.
  for (genvar c = 0; c < CO; c++) begin : g_ch
    fmap_max2 #(.W(I_F_BW)) u_hmax (
      .i_a   (r_h[c*I_F_BW +: I_F_BW]),
      .i_b   (i_in_fmap[c*I_F_BW +: I_F_BW]),
      .o_max (w_hmax[c*I_F_BW +: I_F_BW]),
      .o_b_gt(w_h_gt[c])
    );
    fmap_max2 #(.W(I_F_BW)) u_vmax (
      .i_a   (w_top[c*I_F_BW +: I_F_BW]),
      .i_b   (w_hmax[c*I_F_BW +: I_F_BW]),
      .o_max (w_vmax[c*I_F_BW +: I_F_BW]),
      .o_b_gt(w_v_gt[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_h          <= '0;
      r_ot_valid   <= 1'b0;
      r_ot_fmap    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_ot_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_in_valid) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
        if (!w_x_odd) r_h <= i_in_fmap;
      end
      if (w_win_done) begin
        r_ot_valid   <= 1'b1;
        r_ot_fmap    <= w_vmax;
        r_frame_done <= w_x_last && w_y_last;
      end
    end
  end

  // Every entry is rewritten on each even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (!reset && i_in_valid && w_x_odd && !w_y_odd) r_lb[w_addr] <= w_lb_wr;
  end

`ifdef MAXPOOL_RX_ARGMAX_EN
  logic [CO-1:0]   w_top_hgt;
  logic [CO*2-1:0] w_idx;
  logic [CO*2-1:0] r_ot_idx;

  assign w_lb_wr   = {w_h_gt, w_hmax};
  assign w_top_hgt = w_lb_rd[FW +: CO];

  // Strict-greater selects at both stages make ties resolve to the lowest position.
  always_comb begin
    w_idx = '0;
    for (int c = 0; c < CO; c++) begin
      if (w_v_gt[c]) w_idx[c*2 +: 2] = w_h_gt[c] ? IDX_BR : IDX_BL;
      else           w_idx[c*2 +: 2] = w_top_hgt[c] ? IDX_TR : IDX_TL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           r_ot_idx <= '0;
    else if (w_win_done) r_ot_idx <= w_idx;
  end

  assign o_ot_idx = r_ot_idx;
`else
  logic [CO-1:0] w_sel_unused;
  assign w_sel_unused = w_h_gt & w_v_gt;
  assign w_lb_wr      = w_hmax;
`endif

  assign o_ot_valid   = r_ot_valid;
  assign o_ot_fmap    = r_ot_fmap;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fmap_maxpool_rx.sv
// Self-checking bench for fmap_maxpool_rx: random/structured frames against a
// window-level reference model. Idx checks compile in with MAXPOOL_RX_ARGMAX_EN.
module tb_fmap_maxpool_rx;

  localparam int CO = 3;
  localparam int W  = 20;
  localparam int OX = 24;
  localparam int OY = 24;
  localparam int FW = CO * W;
  localparam int NPIX = OX * OY;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_in_valid;
  logic [FW-1:0] i_in_fmap;
  logic          o_ot_valid;
  logic [FW-1:0] o_ot_fmap;
  logic          o_frame_done;
`ifdef MAXPOOL_RX_ARGMAX_EN
  logic [CO*2-1:0] o_ot_idx;
`endif

  always #5 clk = ~clk;

  fmap_maxpool_rx #(.CO(CO), .I_F_BW(W), .OX(OX), .OY(OY)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (i_in_valid),
    .i_in_fmap   (i_in_fmap),
    .o_ot_valid  (o_ot_valid),
    .o_ot_fmap   (o_ot_fmap),
    .o_frame_done(o_frame_done)
`ifdef MAXPOOL_RX_ARGMAX_EN
    ,
    .o_ot_idx    (o_ot_idx)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stores the frame and pools each window when its last pixel arrives.
  logic [W-1:0]    pix [OY][OX][CO];
  int              m_k;
  logic            exp_valid, exp_done;
  logic [FW-1:0]   exp_fmap;
  logic [CO*2-1:0] exp_idx;

  task automatic model_beat(input logic [FW-1:0] f);
    int x, y;
    logic [W-1:0] w4 [4];
    logic [W-1:0] mx;
    int id;
    x = m_k % OX;
    y = m_k / OX;
    for (int c = 0; c < CO; c++) pix[y][x][c] = f[c*W +: W];
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if ((x % 2 == 1) && (y % 2 == 1)) begin
      for (int c = 0; c < CO; c++) begin
        w4[0] = pix[y-1][x-1][c];
        w4[1] = pix[y-1][x][c];
        w4[2] = pix[y][x-1][c];
        w4[3] = pix[y][x][c];
        mx = w4[0];
        id = 0;
        for (int i = 1; i < 4; i++) if (w4[i] > mx) begin mx = w4[i]; id = i; end
        exp_fmap[c*W +: W]  = mx;
        exp_idx[c*2 +: 2]   = 2'(id);
      end
      exp_valid = 1'b1;
      exp_done  = (m_k == NPIX - 1);
    end
    m_k = (m_k + 1) % NPIX;
  endtask

  function automatic logic [W-1:0] gen_pix(input int mode, input int y, input int x, input int c);
    case (mode)
      0: return W'(y * OX + x);
      1: return W'($urandom);
      2: begin
        if (c == 0) return W'(5);
        if (c == 1) return ((y % 2 == 0) && (x % 2 == 0)) ? W'(1000) : W'(1);
        return '0;
      end
      3: return '1;
      4: return ((y % 2 == 1) && (x % 2 == 1)) ? '1 : W'($urandom_range(0, 32'hFFFFE));
      default: return W'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic run_frame(input int mode, input int gap, input int nbeats, output int pulses,
                           output int dones, output int first_beat, output logic [FW-1:0] last_fmap);
    int sent, guard;
    logic v;
    logic [FW-1:0] f;
    sent = 0; guard = 0; pulses = 0; dones = 0; first_beat = -1; last_fmap = '0;
    while (sent < nbeats && guard < 10 * nbeats + 10) begin
      guard++;
      case (gap)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 1);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      if (v) begin
        for (int c = 0; c < CO; c++) f[c*W +: W] = gen_pix(mode, m_k / OX, m_k % OX, c);
        model_beat(f);
      end else begin
        f = FW'({$urandom, $urandom});
      end
      i_in_valid = v;
      i_in_fmap  = f;
      @(posedge clk);
      #1;
      n_tests++;
      if (o_ot_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL valid mode=%0d beat=%0d got=%b exp=%b", mode, sent, o_ot_valid, exp_valid);
      end
      n_tests++;
      if (o_frame_done !== exp_done) begin
        n_fail++;
        $display("FAIL frame_done mode=%0d beat=%0d got=%b exp=%b", mode, sent, o_frame_done,
                 exp_done);
      end
      n_tests++;
      if (o_ot_fmap !== exp_fmap) begin
        n_fail++;
        $display("FAIL fmap mode=%0d beat=%0d got=%h exp=%h", mode, sent, o_ot_fmap, exp_fmap);
      end
`ifdef MAXPOOL_RX_ARGMAX_EN
      if (exp_valid) begin
        n_tests++;
        if (o_ot_idx !== exp_idx) begin
          n_fail++;
          $display("FAIL idx mode=%0d beat=%0d got=%h exp=%h", mode, sent, o_ot_idx, exp_idx);
        end
      end
`endif
      if (o_ot_valid === 1'b1) begin
        pulses++;
        if (first_beat < 0) first_beat = sent;
        last_fmap = o_ot_fmap;
      end
      if (o_frame_done === 1'b1) dones++;
      if (v) sent++;
    end
    i_in_valid = 1'b0;
    if (sent < nbeats) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_budget mode=%0d got=%0d sent exp=%0d", mode, sent, nbeats);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_in_valid = 1'b1;
      i_in_fmap  = FW'({$urandom, $urandom});
      @(posedge clk);
      #1;
      n_tests++;
      if (o_ot_valid !== 1'b0 || o_frame_done !== 1'b0 || o_ot_fmap !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got v=%b d=%b f=%h exp=0", i, o_ot_valid,
                 o_frame_done, o_ot_fmap);
      end
`ifdef MAXPOOL_RX_ARGMAX_EN
      n_tests++;
      if (o_ot_idx !== '0) begin
        n_fail++;
        $display("FAIL reset_idx got=%h exp=0", o_ot_idx);
      end
`endif
    end
    reset      = 1'b0;
    i_in_valid = 1'b0;
    m_k        = 0;
    exp_fmap   = '0;
  endtask

  task automatic check_full_frame(input string name, input int mode, input int gap);
    int p, d, fb;
    logic [FW-1:0] lf;
    run_frame(mode, gap, NPIX, p, d, fb, lf);
    n_tests++;
    if (p != 144) begin n_fail++; $display("FAIL %s pulses got=%0d exp=144", name, p); end
    n_tests++;
    if (d != 1) begin n_fail++; $display("FAIL %s frame_done_count got=%0d exp=1", name, d); end
    n_tests++;
    if (fb != 25) begin n_fail++; $display("FAIL %s first_pulse_beat got=%0d exp=25", name, fb); end
    if (mode == 0) begin
      n_tests++;
      if (lf[W-1:0] != W'(575)) begin
        n_fail++;
        $display("FAIL %s last_value got=%0d exp=575", name, lf[W-1:0]);
      end
    end
  endtask

  task automatic test_ramp();
    check_full_frame("ramp", 0, 0);
  endtask

  task automatic test_ramp_gaps();
    check_full_frame("ramp_alt", 0, 1);
    check_full_frame("ramp_rand", 0, 2);
  endtask

  task automatic test_channels();
    check_full_frame("channels", 2, 0);
  endtask

  task automatic test_extremes();
    check_full_frame("all_max", 3, 0);
    check_full_frame("br_largest", 4, 2);
  endtask

  task automatic test_random();
    check_full_frame("random", 1, 2);
    check_full_frame("ties", 5, 0);
  endtask

  task automatic test_reset_mid_frame();
    int p, d, fb;
    logic [FW-1:0] lf;
    run_frame(0, 0, 30, p, d, fb, lf);
    test_reset();
    check_full_frame("after_reset", 0, 0);
  endtask

  initial begin
    reset      = 1'b1;
    i_in_valid = 1'b0;
    i_in_fmap  = '0;
    m_k        = 0;
    exp_fmap   = '0;
    exp_idx    = '0;
    test_reset();
    test_ramp();
    test_ramp_gaps();
    test_channels();
    test_extremes();
    test_random();
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
